// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: FSM state encoding, coin
// denominations, and helpers for price lookup and saturating addition.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_DISPENSE = 2'd2
  } vend_state_e;

  // Denomination of coin input bit 0..3.
  localparam int COIN_VAL [4] = '{1, 2, 5, 10};

  // Widest packed price list the slice helper accepts.
  localparam int MAX_PACK_W = 1024;

  // Extract item idx from a packed price list of val_w-bit entries.
  function automatic logic [31:0] price_slice(input logic [MAX_PACK_W-1:0] prices,
                                              input int idx, input int val_w);
    logic [MAX_PACK_W-1:0] shifted;
    logic [31:0]           mask;
    shifted = prices >> (idx * val_w);
    mask    = (val_w >= 32) ? '1 : ((32'd1 << val_w) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

  // a + b clamped to the largest val_w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int val_w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << val_w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/vending_controller_n_if.sv
// Button/coin inputs and binary display outputs of the vending controller.
// master: the input side (buttons, coin acceptor, bench).
// slave : the controller core.
interface vending_controller_n_if #(
  parameter int N_ITEMS = 4,
  parameter int VAL_W   = 7
);
  logic [3:0]         coin;
  logic [N_ITEMS-1:0] select;
  logic               confirm;
  logic               cancel;
  logic               reset_total;
  logic               restock;
  logic [VAL_W-1:0]   price;
  logic [VAL_W-1:0]   balance;
  logic [VAL_W-1:0]   change;
  logic [VAL_W-1:0]   total;
  logic [N_ITEMS-1:0] vend_item;
  logic [N_ITEMS-1:0] sold_out;
  logic               alarm;

  modport master (
    output coin, select, confirm, cancel, reset_total, restock,
    input  price, balance, change, total, vend_item, sold_out, alarm
  );

  modport slave (
    input  coin, select, confirm, cancel, reset_total, restock,
    output price, balance, change, total, vend_item, sold_out, alarm
  );
endinterface

// File: rtl/vending_controller_n_rise_edge.sv
// Rising-edge detector: one register stage of the previous sample plus
// AND-NOT, so a held level produces a single-cycle pulse.
// Ports: clk, rst (async, active-high), din[W], rise[W].
module rise_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;
endmodule

// File: rtl/vending_controller_n.sv
// N-item vending controller core: coin acceptance with balance limit, item
// selection with sold-out check, purchase with change, cancel/refund,
// inactivity timeout, timed dispense pulse and saturating sales total.
// Ports: clk, rst (async, active-high), bus (vending_controller_n_if.slave)
// carrying coin/select/confirm/cancel/reset_total/restock in and
// price/balance/change/total/vend_item/sold_out/alarm out.
module vending_controller_n
  import vending_pkg::*;
#(
  parameter int                         N_ITEMS     = 4,
  parameter int                         VAL_W       = 7,
  parameter logic [N_ITEMS*VAL_W-1:0]   PRICES      = {7'd10, 7'd5, 7'd2, 7'd1},
  parameter int                         MAX_BALANCE = 99,
  parameter int                         STOCK_W     = 4,
  parameter int                         STOCK_INIT  = 9,
  parameter int                         TIMEOUT_CYC = 30,
  parameter int                         HOLD_CYC    = 3
) (
  input logic                   clk,
  input logic                   rst,
  vending_controller_n_if.slave bus
);

  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int HLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);
  localparam logic [VAL_W:0]   BAL_MAX  = (VAL_W+1)'(MAX_BALANCE);

  // Edge detection on every input
  logic [3:0]         coin_e;
  logic [N_ITEMS-1:0] sel_e;
  logic [3:0]         ctrl_e;
  logic               confirm_e, cancel_e, rtot_e, restock_e;

  rise_edge #(.W(4)) u_coin_edge (
    .clk(clk), .rst(rst), .din(bus.coin), .rise(coin_e)
  );
  rise_edge #(.W(N_ITEMS)) u_sel_edge (
    .clk(clk), .rst(rst), .din(bus.select), .rise(sel_e)
  );
  rise_edge #(.W(4)) u_ctrl_edge (
    .clk(clk), .rst(rst),
    .din({bus.restock, bus.reset_total, bus.cancel, bus.confirm}),
    .rise(ctrl_e)
  );

  assign confirm_e = ctrl_e[0];
  assign cancel_e  = ctrl_e[1];
  assign rtot_e    = ctrl_e[2];
  assign restock_e = ctrl_e[3];

  // Controller state
  vend_state_e        state_q, state_d;
  logic [VAL_W-1:0]   bal_q, bal_d;
  logic [VAL_W-1:0]   price_q, price_d;
  logic [VAL_W-1:0]   change_q, change_d;
  logic [VAL_W-1:0]   total_q, total_d;
  logic [N_ITEMS-1:0] vend_q, vend_d;
  logic               alarm_q, alarm_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [HLD_W-1:0]   hold_q, hold_d;

  logic [N_ITEMS-1:0] stock_dec;
  logic               stock_load;
  logic [N_ITEMS-1:0] sold_out_w;

  logic [VAL_W-1:0]   coin_val;
  logic [VAL_W:0]     bal_sum;
  logic [IDX_W-1:0]   sel_new;
  logic               grp_accept;
  logic               accept;
  logic               reject;
  logic               do_refund;
  logic               timeout;

  always_comb begin
    state_d    = state_q;
    bal_d      = bal_q;
    price_d    = price_q;
    change_d   = change_q;
    total_d    = total_q;
    vend_d     = vend_q;
    alarm_d    = alarm_q;
    sel_idx_d  = sel_idx_q;
    timer_d    = '0;
    hold_d     = hold_q;
    stock_dec  = '0;
    stock_load = 1'b0;
    coin_val   = '0;
    sel_new    = '0;
    grp_accept = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    do_refund  = 1'b0;
    timeout    = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if (coin_e[b]) coin_val = VAL_W'(COIN_VAL[b]);
    end
    bal_sum = {1'b0, bal_q} + {1'b0, coin_val};

    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_e[i]) sel_new = IDX_W'(i);
    end

    // Only the highest-priority edge present acts; the rest are dropped.
    unique case (state_q)
      ST_IDLE, ST_SELECTED: begin
        if (cancel_e) begin
          do_refund  = 1'b1;
          grp_accept = 1'b1;
        end else if (confirm_e) begin
          if (state_q == ST_SELECTED && bal_q >= price_q) begin
            change_d   = bal_q - price_q;
            bal_d      = '0;
            total_d    = VAL_W'(sat_add(32'(total_q), 32'(price_q), VAL_W));
            stock_dec[sel_idx_q] = 1'b1;
            vend_d     = N_ITEMS'(1) << sel_idx_q;
            hold_d     = '0;
            state_d    = ST_DISPENSE;
            grp_accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end else if (|sel_e) begin
          if ($onehot(sel_e) && !sold_out_w[sel_new]) begin
            sel_idx_d  = sel_new;
            price_d    = VAL_W'(price_slice(MAX_PACK_W'(PRICES), int'(sel_new), VAL_W));
            state_d    = ST_SELECTED;
            grp_accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end else if (|coin_e) begin
          if ($onehot(coin_e) && bal_sum <= BAL_MAX) begin
            bal_d      = bal_sum[VAL_W-1:0];
            change_d   = '0;
            grp_accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end

        // A rejected action does not count as activity, so the timeout
        // still fires alongside it.
        timeout = (state_q == ST_SELECTED) && !grp_accept && (timer_q == TMR_LAST);
        if (timeout) do_refund = 1'b1;

        if (do_refund) begin
          change_d  = bal_q;
          bal_d     = '0;
          price_d   = '0;
          sel_idx_d = '0;
          state_d   = ST_IDLE;
        end

        if (state_q == ST_SELECTED && state_d == ST_SELECTED && !grp_accept)
          timer_d = timer_q + TMR_W'(1);
      end

      ST_DISPENSE: begin
        // Higher-priority edges are ignored here but still mask coins.
        if (!(cancel_e || confirm_e || (|sel_e)) && (|coin_e)) reject = 1'b1;

        if (hold_q == HLD_LAST) begin
          state_d   = ST_IDLE;
          vend_d    = '0;
          price_d   = '0;
          sel_idx_d = '0;
        end else begin
          hold_d = hold_q + HLD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    accept = grp_accept | do_refund;

    // Clearing the total overrides a same-cycle sale.
    if (rtot_e) begin
      total_d = '0;
      accept  = 1'b1;
    end

    if (restock_e) begin
      if (state_q == ST_IDLE) begin
        stock_load = 1'b1;
        accept     = 1'b1;
      end else begin
        reject = 1'b1;
      end
    end

    if (reject)      alarm_d = 1'b1;
    else if (accept) alarm_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bal_q     <= '0;
      price_q   <= '0;
      change_q  <= '0;
      total_q   <= '0;
      vend_q    <= '0;
      alarm_q   <= 1'b0;
      sel_idx_q <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      price_q   <= price_d;
      change_q  <= change_d;
      total_q   <= total_d;
      vend_q    <= vend_d;
      alarm_q   <= alarm_d;
      sel_idx_q <= sel_idx_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
    end
  end

  // Per-item stock down-counters
  for (genvar g = 0; g < N_ITEMS; g++) begin : g_stock
    logic [STOCK_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (stock_load)                       cnt_d = STOCK_W'(STOCK_INIT);
      else if (stock_dec[g] && cnt_q != '0) cnt_d = cnt_q - STOCK_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= STOCK_W'(STOCK_INIT);
      else     cnt_q <= cnt_d;
    end

    assign sold_out_w[g] = (cnt_q == '0);
  end

  assign bus.price     = price_q;
  assign bus.balance   = bal_q;
  assign bus.change    = change_q;
  assign bus.total     = total_q;
  assign bus.vend_item = vend_q;
  assign bus.sold_out  = sold_out_w;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_vending_controller_n.sv
module tb_vending_controller_n;

  localparam int N  = 4;
  localparam int VW = 7;
  localparam int TO = 30;
  localparam int HC = 3;
  localparam int MAXB = 99;
  localparam int SINIT = 9;
  localparam int TOT_MAX = (1 << VW) - 1;

  localparam int ST_I = 0;
  localparam int ST_S = 1;
  localparam int ST_D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vending_controller_n_if #(.N_ITEMS(N), .VAL_W(VW)) bus ();

  vending_controller_n #(
    .N_ITEMS(N), .VAL_W(VW), .PRICES({7'd10, 7'd5, 7'd2, 7'd1}),
    .MAX_BALANCE(MAXB), .STOCK_W(4), .STOCK_INIT(SINIT),
    .TIMEOUT_CYC(TO), .HOLD_CYC(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] price;
    logic [VW-1:0] balance;
    logic [VW-1:0] change;
    logic [VW-1:0] total;
    logic [N-1:0]  vend;
    logic [N-1:0]  sold;
    logic          alarm;
  } snap_t;

  snap_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: plain integers following the machine's rules.
  int pr_tab [N] = '{1, 2, 5, 10};
  int cv_tab [4] = '{1, 2, 5, 10};
  int m_state, m_bal, m_price, m_change, m_total, m_alarm, m_sel;
  int m_idle, m_hold_left;
  int m_vend;
  int m_stock [N];
  logic [3:0] p_coin;
  logic [N-1:0] p_sel;
  logic p_cf, p_cn, p_rt, p_rs;

  task automatic model_reset();
    m_state = ST_I; m_bal = 0; m_price = 0; m_change = 0; m_total = 0;
    m_alarm = 0; m_sel = 0; m_idle = 0; m_hold_left = 0; m_vend = 0;
    for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    p_coin = '0; p_sel = '0; p_cf = 0; p_cn = 0; p_rt = 0; p_rs = 0;
  endtask

  task automatic model_refund();
    m_change = m_bal; m_bal = 0; m_price = 0; m_sel = 0; m_state = ST_I;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [N-1:0] s,
                            input logic cf, input logic cn, input logic rt, input logic rs);
    logic [3:0]   ce;
    logic [N-1:0] se;
    logic cfe, cne, rte, rse;
    int orig, idx, val;
    bit acc, rej, grp;
    ce = c & ~p_coin; se = s & ~p_sel;
    cfe = cf & ~p_cf; cne = cn & ~p_cn; rte = rt & ~p_rt; rse = rs & ~p_rs;
    p_coin = c; p_sel = s; p_cf = cf; p_cn = cn; p_rt = rt; p_rs = rs;
    orig = m_state; acc = 0; rej = 0; grp = 0;
    if (orig == ST_D) begin
      if (!(cne || cfe || se != 0) && ce != 0) rej = 1;
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_state = ST_I; m_vend = 0; m_price = 0; m_sel = 0;
      end
    end else begin
      if (cne) begin
        model_refund(); grp = 1;
      end else if (cfe) begin
        if (orig == ST_S && m_bal >= m_price) begin
          m_change = m_bal - m_price; m_bal = 0;
          m_total = (m_total + m_price > TOT_MAX) ? TOT_MAX : m_total + m_price;
          m_stock[m_sel]--; m_vend = 1 << m_sel; m_hold_left = HC;
          m_state = ST_D; grp = 1;
        end else rej = 1;
      end else if (se != 0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (se[i]) idx = i;
        if ($countones(se) == 1 && m_stock[idx] > 0) begin
          m_sel = idx; m_price = pr_tab[idx]; m_state = ST_S; grp = 1;
        end else rej = 1;
      end else if (ce != 0) begin
        val = 0;
        for (int b = 0; b < 4; b++) if (ce[b]) val = cv_tab[b];
        if ($countones(ce) == 1 && m_bal + val <= MAXB) begin
          m_bal += val; m_change = 0; grp = 1;
        end else rej = 1;
      end
      acc = grp;
      if (orig == ST_S && !grp) begin
        m_idle++;
        if (m_idle >= TO) begin
          model_refund(); acc = 1;
        end
      end
      if (m_state != ST_S) m_idle = 0;
      if (grp) m_idle = 0;
    end
    if (rte) begin
      m_total = 0; acc = 1;
    end
    if (rse) begin
      if (orig == ST_I) begin
        for (int i = 0; i < N; i++) m_stock[i] = SINIT;
        acc = 1;
      end else rej = 1;
    end
    if (rej) m_alarm = 1;
    else if (acc) m_alarm = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t e;
    e.price = VW'(m_price); e.balance = VW'(m_bal); e.change = VW'(m_change);
    e.total = VW'(m_total); e.vend = N'(m_vend); e.alarm = (m_alarm != 0);
    for (int i = 0; i < N; i++) e.sold[i] = (m_stock[i] == 0);
    return e;
  endfunction

  // Stimulus: one call per clock cycle; pushes the expected post-edge outputs.
  task automatic drive(input logic [3:0] c, input logic [N-1:0] s, input logic cf,
                       input logic cn, input logic rt, input logic rs, input logic r);
    @(posedge clk);
    #2;
    cyc++;
    rst = r;
    bus.coin = c; bus.select = s; bus.confirm = cf; bus.cancel = cn;
    bus.reset_total = rt; bus.restock = rs;
    if (r) model_reset();
    else   model_step(c, s, cf, cn, rt, rs);
    exp_q.push_back(model_snap());
  endtask

  task automatic step(input logic [3:0] c, input logic [N-1:0] s, input logic cf,
                      input logic cn, input logic rt, input logic rs);
    drive(c, s, cf, cn, rt, rs, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 0, 0, 0, 0);
  endtask

  task automatic coin_pulse(input int b);
    step(4'(1 << b), '0, 0, 0, 0, 0); idle(1);
  endtask

  task automatic sel_pulse(input int i);
    step('0, N'(1 << i), 0, 0, 0, 0); idle(1);
  endtask

  task automatic confirm_pulse();
    step('0, '0, 1, 0, 0, 0); idle(1);
  endtask

  // Monitor: compares every registered output once per cycle.
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL cyc=%0d %s got=%0d exp=%0d", cyc, nm, got, exp);
    end
  endtask

  snap_t cur;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("price",    32'(bus.price),     32'(cur.price));
        chk("balance",  32'(bus.balance),   32'(cur.balance));
        chk("change",   32'(bus.change),    32'(cur.change));
        chk("total",    32'(bus.total),     32'(cur.total));
        chk("vend_item",32'(bus.vend_item), 32'(cur.vend));
        chk("sold_out", 32'(bus.sold_out),  32'(cur.sold));
        chk("alarm",    32'(bus.alarm),     32'(cur.alarm));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   rc;
    logic [N-1:0] rs_sel;
    bus.coin = '0; bus.select = '0; bus.confirm = 0; bus.cancel = 0;
    bus.reset_total = 0; bus.restock = 0;
    model_reset();

    // Reset state
    drive('0, '0, 0, 0, 0, 0, 1'b1);
    drive('0, '0, 0, 0, 0, 0, 1'b1);
    idle(2);

    // Coins 5,5, buy item 3 (price 10)
    coin_pulse(2); coin_pulse(2); sel_pulse(3); confirm_pulse(); idle(5);

    // Coins 10,2, buy item 2 (price 5), change 7; second confirm in IDLE rejected
    coin_pulse(3); coin_pulse(1); sel_pulse(2); confirm_pulse(); idle(5);
    confirm_pulse();

    // Balance 95 then overflow coin, then two coins in one cycle
    repeat (9) coin_pulse(3);
    coin_pulse(2);
    coin_pulse(3);
    step(4'b0011, '0, 0, 0, 0, 0); idle(1);
    step('0, '0, 0, 1, 0, 0); idle(1);

    // Timeout refund
    sel_pulse(1); coin_pulse(1); idle(TO + 4);

    // Exhaust item 0, select sold-out, restock
    repeat (9) begin
      coin_pulse(0); sel_pulse(0); confirm_pulse(); idle(4);
    end
    sel_pulse(0);
    step('0, '0, 0, 0, 0, 1); idle(2);

    // reset_total together with confirm
    coin_pulse(3); sel_pulse(3);
    step('0, '0, 1, 0, 1, 0); idle(5);

    // rst during DISPENSE
    coin_pulse(3); sel_pulse(3); step('0, '0, 1, 0, 0, 0); idle(1);
    drive('0, '0, 0, 0, 0, 0, 1'b1);
    drive('0, '0, 0, 0, 0, 0, 1'b1);
    idle(2);

    // Randomized traffic with quiet stretches and occasional reset
    for (int k = 0; k < 3000; k++) begin
      if ((k % 250) < 40) begin
        idle(1);
      end else if ($urandom_range(0, 499) == 0) begin
        drive('0, '0, 0, 0, 0, 0, 1'b1);
        drive('0, '0, 0, 0, 0, 0, 1'b1);
      end else begin
        rc = '0; rs_sel = '0;
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rc[b] = 1'b1;
        for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) rs_sel[i] = 1'b1;
        step(rc, rs_sel, ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0));
      end
    end

    idle(2);
    @(posedge clk);
    #3;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
